// File: rtl/ripple_down_timer.sv
// ripple_down_timer: programmable WIDTH-bit down-counter/timer.
// Loads a value on start, counts to zero, pulses tc at terminal count, then
// either stops in DONE (one-shot) or reloads and keeps running (auto_reload).
// Optional build macro RIPPLE_DOWN_TIMER_PRESCALE_EN adds a tick input that
// gates the decrement and terminal-count action while running.
module ripple_down_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
`ifdef RIPPLE_DOWN_TIMER_PRESCALE_EN
  input  logic             tick,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             step;

  // Count-enable: prescaler tick when built with it, otherwise every cycle
`ifdef RIPPLE_DOWN_TIMER_PRESCALE_EN
  assign step = tick;
`else
  assign step = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start restarts from any state, pause/no-step holds
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          state_d = RUN;
        end else if (pause || !step) begin
          state_d = RUN;
        end else if (count == '0) begin
          state_d = auto_reload ? RUN : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: load, decrement, terminal-count action
  always_comb begin
    count_d  = count;
    reload_d = reload_q;
    tc_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          count_d  = load_val;
          reload_d = load_val;
        end else begin
          count_d = '0;
        end
      end
      RUN: begin
        if (start) begin
          count_d  = load_val;
          reload_d = load_val;
        end else if (!pause && step) begin
          if (count != '0) begin
            count_d = count - WIDTH'(1);
          end else begin
            tc_d    = 1'b1;
            count_d = auto_reload ? reload_q : '0;
          end
        end
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  // Registered outputs and reload value; busy/done track the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      count    <= count_d;
      reload_q <= reload_d;
      tc       <= tc_d;
      busy     <= (state_d == RUN);
      done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_ripple_down_timer.sv
// Testbench for ripple_down_timer: table-driven directed vectors plus
// hand-written sequences for reload period and the prescale build.
module tb_ripple_down_timer;

  localparam int unsigned WIDTH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
`ifdef RIPPLE_DOWN_TIMER_PRESCALE_EN
  logic             tick;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             rst;
    logic             st;
    logic [WIDTH-1:0] lv;
    logic             ar;
    logic             ps;
    logic [WIDTH-1:0] exp_count;
    logic             exp_busy;
    logic             exp_tc;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  ripple_down_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef RIPPLE_DOWN_TIMER_PRESCALE_EN
    .tick       (tick),
`endif
    .start      (start),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .pause      (pause),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic st, input int lv, input logic ar,
                     input logic ps, input int ec, input logic eb, input logic et,
                     input logic ed);
    vec_t v;
    v.rst       = rst;
    v.st        = st;
    v.lv        = WIDTH'(lv);
    v.ar        = ar;
    v.ps        = ps;
    v.exp_count = WIDTH'(ec);
    v.exp_busy  = eb;
    v.exp_tc    = et;
    v.exp_done  = ed;
    vecs.push_back(v);
  endtask

  // Apply inputs for one rising edge, then sample 1 time unit after it
  task automatic step(input logic rst, input logic st, input int lv, input logic ar,
                      input logic ps);
    reset       = rst;
    start       = st;
    load_val    = WIDTH'(lv);
    auto_reload = ar;
    pause       = ps;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [WIDTH-1:0] ec,
                       input logic eb, input logic et, input logic ed);
    checks++;
    if (count !== ec || busy !== eb || tc !== et || done !== ed) begin
      errors++;
      $display("FAIL %s[%0d]: got count=%0d busy=%0b tc=%0b done=%0b, want count=%0d busy=%0b tc=%0b done=%0b",
               name, idx, count, busy, tc, done, ec, eb, et, ed);
    end
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    start       = 1'b0;
    load_val    = '0;
    auto_reload = 1'b0;
    pause       = 1'b0;
`ifdef RIPPLE_DOWN_TIMER_PRESCALE_EN
    tick        = 1'b1;
`endif

    //   rst st lv ar ps   count busy tc done
    add(1, 0, 0, 0, 0,    0, 0, 0, 0);   // reset state
    add(0, 0, 5, 0, 0,    0, 0, 0, 0);   // idle ignores load_val
    // one-shot, load 3
    add(0, 1, 3, 0, 0,    3, 1, 0, 0);
    add(0, 0, 0, 0, 0,    2, 1, 0, 0);
    add(0, 0, 0, 0, 0,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    add(0, 0, 0, 0, 0,    0, 0, 0, 1);   // tc is one cycle, done holds
    // auto-reload, load 2, started from DONE
    add(0, 1, 2, 1, 0,    2, 1, 0, 0);
    add(0, 0, 0, 1, 0,    1, 1, 0, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 0, 0, 1, 0,    2, 1, 1, 0);
    add(0, 0, 0, 1, 0,    1, 1, 0, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 0, 0, 1, 0,    2, 1, 1, 0);
    add(0, 0, 0, 1, 0,    1, 1, 0, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);   // auto_reload dropped at tc
    // pause at count 3 for 4 cycles
    add(0, 1, 5, 0, 0,    5, 1, 0, 0);
    add(0, 0, 0, 0, 0,    4, 1, 0, 0);
    add(0, 0, 0, 0, 0,    3, 1, 0, 0);
    add(0, 0, 0, 0, 1,    3, 1, 0, 0);
    add(0, 0, 0, 0, 1,    3, 1, 0, 0);
    add(0, 0, 0, 0, 1,    3, 1, 0, 0);
    add(0, 0, 0, 0, 1,    3, 1, 0, 0);
    add(0, 0, 0, 0, 0,    2, 1, 0, 0);
    add(0, 0, 0, 0, 0,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    // pause coinciding with terminal count defers tc
    add(0, 1, 1, 0, 0,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 1,    0, 1, 0, 0);
    add(0, 0, 0, 0, 1,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    // restart at count 4 from max load
    add(0, 1, 7, 0, 0,    7, 1, 0, 0);
    add(0, 0, 0, 0, 0,    6, 1, 0, 0);
    add(0, 0, 0, 0, 0,    5, 1, 0, 0);
    add(0, 0, 0, 0, 0,    4, 1, 0, 0);
    add(0, 1, 1, 0, 0,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    // restart with pause=1 while count==0: start wins, no tc
    add(0, 1, 2, 0, 0,    2, 1, 0, 0);
    add(0, 0, 0, 0, 0,    1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 1, 3, 0, 1,    3, 1, 0, 0);
    add(0, 0, 0, 0, 0,    2, 1, 0, 0);
    // load 0 from RUN then from DONE
    add(0, 1, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    add(0, 1, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 1, 1);
    // reset at count 3, with start also high
    add(0, 1, 6, 0, 0,    6, 1, 0, 0);
    add(0, 0, 0, 0, 0,    5, 1, 0, 0);
    add(0, 0, 0, 0, 0,    4, 1, 0, 0);
    add(0, 0, 0, 0, 0,    3, 1, 0, 0);
    add(1, 1, 5, 0, 0,    0, 0, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0, 0);
    // reset while paused
    add(0, 1, 4, 0, 0,    4, 1, 0, 0);
    add(0, 0, 0, 0, 1,    4, 1, 0, 0);
    add(1, 0, 0, 0, 1,    0, 0, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].st, int'(vecs[i].lv), vecs[i].ar, vecs[i].ps);
      check("vec", i, vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_tc, vecs[i].exp_done);
    end

    // Auto-reload tc period with load 3 must be 4 cycles
    step(0, 1, 3, 1, 0);
    check("ar_start", 0, 3'd3, 1'b1, 1'b0, 1'b0);
    n = 0;
    do begin
      step(0, 0, 0, 1, 0);
      n++;
    end while (!tc && n < 20);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL ar_first_tc: got %0d cycles, want 4", n);
    end
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        step(0, 0, 0, 1, 0);
        n++;
      end while (!tc && n < 20);
      checks++;
      if (n != 4 || busy !== 1'b1 || count !== 3'd3) begin
        errors++;
        $display("FAIL ar_period[%0d]: got %0d cycles busy=%0b count=%0d, want 4 cycles busy=1 count=3",
                 k, n, busy, count);
      end
    end
    step(1, 0, 0, 0, 0);
    check("ar_reset", 0, 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef RIPPLE_DOWN_TIMER_PRESCALE_EN
    // Prescaled run: load 2, tick every third cycle; start ignores tick
    tick = 1'b0;
    step(0, 1, 2, 0, 0);
    check("ps_start", 0, 3'd2, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 9; t++) begin
      int ec;
      ec   = (t < 3) ? 2 : (t < 6) ? 1 : 0;
      tick = ((t % 3) == 0);
      step(0, 0, 0, 0, 0);
      check("ps_step", t, WIDTH'(ec), (t != 9), (t == 9), (t == 9));
    end
    tick = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_down_timer.md
Name: ripple_down_timer

Overview:
- Programmable WIDTH-bit down-counter/timer. Counts from a loaded value toward 0, flags terminal count, then stops or auto-reloads.
- It is the down-direction companion to the team's 3-bit up counter.
- Used as a countdown/interval generator beside the counter blocks.
- Fully synchronous to clk. No derived clocks.

Parameters:
- WIDTH, 3, bit width of the count and the load value.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request: capture load_val and begin counting
- load_val  input  WIDTH  start/reload value, sampled only when start=1
- auto_reload  input  1  1 = reload at terminal count and keep running; 0 = one-shot; sampled each terminal-count cycle
- pause  input  1  1 = hold count and state (RUN only)
- count  output  WIDTH  current count value (registered)
- busy  output  1  1 while in RUN
- tc  output  1  registered one-cycle terminal-count pulse
- done  output  1  1 while in DONE (one-shot finished)

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, count=0, reload_reg=0, busy=0, tc=0, done=0. Reset has priority over every other input, including mid-RUN and mid-pause.
- States: IDLE, RUN, DONE. busy=(state==RUN), done=(state==DONE); both are registered.
- tc defaults to 0 every cycle unless set by the terminal-count rule below.
- IDLE:
  - start=1: count<=load_val, reload_reg<=load_val, go to RUN.
  - Otherwise hold, count=0.
- RUN, priority high to low:
  - start=1: restart. count<=load_val, reload_reg<=load_val, stay RUN, no tc, even if count==0 or pause=1.
  - pause=1: hold count and state, no tc.
  - count!=0: count<=count-1.
  - count==0 (terminal count): tc<=1 for exactly one cycle.
    - auto_reload=1: count<=reload_reg, stay RUN.
    - auto_reload=0: count stays 0, go to DONE.
- DONE:
  - start=1: same as IDLE start.
  - Otherwise hold (count=0, done=1).
- Timing:
  - One-shot with load_val=N: start accepted at edge E0. count=N after E0, reaches 0 after E(N). tc=1 and done=1 after E(N+1).
  - Auto-reload: tc period = N+1 clk cycles.
- load_val=0: count reads 0 for one cycle, then tc is asserted at the next edge.
- Arithmetic is unsigned WIDTH-bit; the decrement never underflows because count==0 is handled explicitly. load_val=2^WIDTH-1 is legal.
- Simultaneous pause and terminal count: pause wins; tc is deferred until pause drops.

Optional Feature:
- Macro: RIPPLE_DOWN_TIMER_PRESCALE_EN.
- Defined:
  - Adds input tick (1 bit).
  - In RUN, count decrement and terminal-count action happen only on edges with tick=1 and pause=0. Otherwise hold.
  - start and reset ignore tick.
- Not defined: no tick port; behaves as tick=1 every cycle.

Test Plan:
- Reset, then start with load_val=3, auto_reload=0 -> count 3,2,1,0 on successive cycles; next cycle tc=1 (one cycle), done=1, busy=0, count held 0.
- Start load_val=2, auto_reload=1, run 9 cycles -> count 2,1,0,2,1,0,2,1,0; tc pulses every 3 cycles; busy stays 1.
- Start load_val=5, pause=1 for 4 cycles after count reaches 3 -> count held at 3 for 4 cycles, then 2,1,0; tc delayed by exactly 4 cycles.
- Start load_val=7 with WIDTH=3; re-assert start with load_val=1 when count=4 -> count becomes 1, then 0, then tc; no tc at the restart edge.
- Start load_val=0 -> count 0 for one cycle, then tc=1 and done=1. Separately, start load_val=6 and assert reset when count=3 -> next cycle count=0, IDLE, busy=tc=done=0.
- Prescale build, load_val=2, tick high every 3rd cycle -> count steps only on tick cycles; tc occurs on the 3rd tick after start.
